inst_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the processor control unit. On a fetch request from the control unit (its `stb_o`/`cyc_o` in FETCH state), the unit runs a Wishbone-classic read of the instruction word at the current PC. It latches the word into an instruction register and returns a one-cycle `inst_ack` plus the decoded `op`/`func` fields that the control unit consumes in DECODE and later states. It also provides flush and bus-timeout handling.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_watchdog.sv | 29 ++
 rtl/inst_fetch_unit.sv | 134 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and field widths for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned FUNC_W     = 3;
  localparam int unsigned INST_W_DEF = 18;
  localparam int unsigned PC_W_DEF   = 12;

endpackage

// File: rtl/fetch_watchdog.sv
// Clearable saturating counter of un-acked bus cycles; flags the last allowed cycle.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // High while the current cycle would be the TIMEOUT-th one without an ack.
  assign expired = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: Wishbone-classic read at the requested PC, latched into the IR.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned INST_W  = INST_W_DEF,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cu_stb_i,
  input  logic              cu_cyc_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              flush_i,
  input  logic              err_clr_i,
  output logic [PC_W-1:0]   iwb_adr_o,
  output logic              iwb_cyc_o,
  output logic              iwb_stb_o,
  input  logic [INST_W-1:0] iwb_dat_i,
  input  logic              iwb_ack_i,
  output logic              inst_ack_o,
  output logic [INST_W-1:0] inst_o,
  output logic [OP_W-1:0]   op_o,
  output logic [FUNC_W-1:0] func_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  fetch_state_t state, state_nxt;

  logic req;
  logic accept;
  logic load;
  logic tmo;
  logic wd_inc;
  logic wd_expired;

  assign req = cu_stb_i & cu_cyc_i;

  fetch_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT priority: flush, then ack, then watchdog abort.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    tmo       = 1'b0;
    wd_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !flush_i) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (iwb_ack_i) begin
          load      = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_inc = 1'b1;
          if (wd_expired) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes and the ack pulse are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iwb_cyc_o  <= 1'b0;
      iwb_stb_o  <= 1'b0;
      inst_ack_o <= 1'b0;
    end else begin
      iwb_cyc_o  <= (state_nxt == WAIT);
      iwb_stb_o  <= (state_nxt == WAIT);
      inst_ack_o <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iwb_adr_o <= '0;
    end else if (accept) begin
      iwb_adr_o <= pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o <= '0;
    end else if (load) begin
      inst_o <= iwb_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_o <= 1'b0;
    end else if (tmo) begin
      timeout_err_o <= 1'b1;
    end else if (err_clr_i) begin
      timeout_err_o <= 1'b0;
    end
  end

  assign op_o   = inst_o[INST_W-1 -: OP_W];
  assign func_o = inst_o[FUNC_W-1:0];
  assign busy_o = (state == WAIT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (TIMEOUT=4).
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        cu_stb_i;
  logic        cu_cyc_i;
  logic [11:0] pc_i;
  logic        flush_i;
  logic        err_clr_i;
  logic [11:0] iwb_adr_o;
  logic        iwb_cyc_o;
  logic        iwb_stb_o;
  logic [17:0] iwb_dat_i;
  logic        iwb_ack_i;
  logic        inst_ack_o;
  logic [17:0] inst_o;
  logic [6:0]  op_o;
  logic [2:0]  func_o;
  logic        busy_o;
  logic        timeout_err_o;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit #(
    .INST_W (18),
    .PC_W   (12),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cu_stb_i     (cu_stb_i),
    .cu_cyc_i     (cu_cyc_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .err_clr_i    (err_clr_i),
    .iwb_adr_o    (iwb_adr_o),
    .iwb_cyc_o    (iwb_cyc_o),
    .iwb_stb_o    (iwb_stb_o),
    .iwb_dat_i    (iwb_dat_i),
    .iwb_ack_i    (iwb_ack_i),
    .inst_ack_o   (inst_ack_o),
    .inst_o       (inst_o),
    .op_o         (op_o),
    .func_o       (func_o),
    .busy_o       (busy_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic on, input logic [11:0] pc);
    cu_stb_i = on;
    cu_cyc_i = on;
    pc_i     = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".adr"},  32'(iwb_adr_o), 32'h0);
    check({tag, ".cyc"},  32'(iwb_cyc_o), 32'h0);
    check({tag, ".stb"},  32'(iwb_stb_o), 32'h0);
    check({tag, ".iack"}, 32'(inst_ack_o), 32'h0);
    check({tag, ".inst"}, 32'(inst_o), 32'h0);
    check({tag, ".op"},   32'(op_o), 32'h0);
    check({tag, ".func"}, 32'(func_o), 32'h0);
    check({tag, ".busy"}, 32'(busy_o), 32'h0);
    check({tag, ".terr"}, 32'(timeout_err_o), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    cu_stb_i  = 1'b0;
    cu_cyc_i  = 1'b0;
    pc_i      = '0;
    flush_i   = 1'b0;
    err_clr_i = 1'b0;
    iwb_dat_i = '0;
    iwb_ack_i = 1'b0;
    #3;
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // Zero-wait fetch
    request(1'b1, 12'h004);
    check("zw.c0.busy", 32'(busy_o), 32'h0);
    step();
    check("zw.c1.cyc", 32'(iwb_cyc_o), 32'h1);
    check("zw.c1.stb", 32'(iwb_stb_o), 32'h1);
    check("zw.c1.adr", 32'(iwb_adr_o), 32'h004);
    check("zw.c1.busy", 32'(busy_o), 32'h1);
    check("zw.c1.iack", 32'(inst_ack_o), 32'h0);
    request(1'b0, 12'h000);
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h3F005;
    step();
    iwb_ack_i = 1'b0;
    check("zw.c2.iack", 32'(inst_ack_o), 32'h1);
    check("zw.c2.inst", 32'(inst_o), 32'h3F005);
    check("zw.c2.op", 32'(op_o), 32'h7E);
    check("zw.c2.func", 32'(func_o), 32'h5);
    check("zw.c2.cyc", 32'(iwb_cyc_o), 32'h0);
    step();
    check("zw.c3.iack", 32'(inst_ack_o), 32'h0);
    check("zw.c3.op", 32'(op_o), 32'h7E);

    // Wait states: ack in the third stb cycle
    request(1'b1, 12'h123);
    step();
    request(1'b0, 12'hFFF);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("ws.c%0d.busy", i), 32'(busy_o), 32'h1);
      check($sformatf("ws.c%0d.iack", i), 32'(inst_ack_o), 32'h0);
      check($sformatf("ws.c%0d.inst", i), 32'(inst_o), 32'h3F005);
      check($sformatf("ws.c%0d.adr", i), 32'(iwb_adr_o), 32'h123);
      if (i == 3) begin
        iwb_ack_i = 1'b1;
        iwb_dat_i = 18'h2A5C3;
      end
      step();
    end
    iwb_ack_i = 1'b0;
    check("ws.c4.iack", 32'(inst_ack_o), 32'h1);
    check("ws.c4.inst", 32'(inst_o), 32'h2A5C3);
    check("ws.c4.op", 32'(op_o), 32'h54);
    check("ws.c4.func", 32'(func_o), 32'h3);
    check("ws.c4.busy", 32'(busy_o), 32'h0);
    step();

    // Flush with coincident ack
    request(1'b1, 12'h010);
    step();
    request(1'b0, 12'h000);
    step();
    check("fl.c2.stb", 32'(iwb_stb_o), 32'h1);
    flush_i   = 1'b1;
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h00001;
    step();
    flush_i   = 1'b0;
    iwb_ack_i = 1'b0;
    check("fl.c3.cyc", 32'(iwb_cyc_o), 32'h0);
    check("fl.c3.stb", 32'(iwb_stb_o), 32'h0);
    check("fl.c3.iack", 32'(inst_ack_o), 32'h0);
    check("fl.c3.busy", 32'(busy_o), 32'h0);
    check("fl.c3.inst", 32'(inst_o), 32'h2A5C3);
    step();
    check("fl.c4.iack", 32'(inst_ack_o), 32'h0);
    check("fl.c4.inst", 32'(inst_o), 32'h2A5C3);

    // Timeout with request held, then automatic retry
    request(1'b1, 12'h0AB);
    step();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to.c%0d.stb", i), 32'(iwb_stb_o), 32'h1);
      check($sformatf("to.c%0d.terr", i), 32'(timeout_err_o), 32'h0);
      step();
    end
    check("to.c5.stb", 32'(iwb_stb_o), 32'h0);
    check("to.c5.terr", 32'(timeout_err_o), 32'h1);
    check("to.c5.iack", 32'(inst_ack_o), 32'h0);
    check("to.c5.busy", 32'(busy_o), 32'h0);
    step();
    check("to.c6.retry", 32'(iwb_stb_o), 32'h1);
    check("to.c6.adr", 32'(iwb_adr_o), 32'h0AB);
    request(1'b0, 12'h000);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("to.c7.clr", 32'(timeout_err_o), 32'h0);
    step();
    step();
    // Fourth un-acked cycle of the retry: ack arrives and must win
    check("to.c9.stb", 32'(iwb_stb_o), 32'h1);
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h0ABCD;
    step();
    iwb_ack_i = 1'b0;
    check("to.c10.iack", 32'(inst_ack_o), 32'h1);
    check("to.c10.inst", 32'(inst_o), 32'h0ABCD);
    check("to.c10.op", 32'(op_o), 32'h15);
    check("to.c10.func", 32'(func_o), 32'h5);
    check("to.c10.terr", 32'(timeout_err_o), 32'h0);
    step();

    // Timeout coinciding with err_clr: set wins, clear applies afterwards
    request(1'b1, 12'h0C0);
    step();
    request(1'b0, 12'h000);
    step();
    step();
    step();
    check("tc.c4.stb", 32'(iwb_stb_o), 32'h1);
    err_clr_i = 1'b1;
    step();
    check("tc.c5.terr", 32'(timeout_err_o), 32'h1);
    check("tc.c5.stb", 32'(iwb_stb_o), 32'h0);
    step();
    err_clr_i = 1'b0;
    check("tc.c6.terr", 32'(timeout_err_o), 32'h0);

    // Async reset mid-WAIT with a pending ack
    request(1'b1, 12'h055);
    step();
    request(1'b0, 12'h000);
    check("ar.c1.cyc", 32'(iwb_cyc_o), 32'h1);
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h11111;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("ar.async");
    #2;
    rst       = 1'b0;
    iwb_ack_i = 1'b0;
    step();
    check("ar.post.iack", 32'(inst_ack_o), 32'h0);
    check("ar.post.inst", 32'(inst_o), 32'h0);
    request(1'b1, 12'h7FF);
    step();
    request(1'b0, 12'h000);
    check("ar.re.adr", 32'(iwb_adr_o), 32'h7FF);
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h3F005;
    step();
    iwb_ack_i = 1'b0;
    check("ar.re.iack", 32'(inst_ack_o), 32'h1);
    check("ar.re.inst", 32'(inst_o), 32'h3F005);
    step();

    // Back-to-back with request and ack held high
    request(1'b1, 12'h020);
    iwb_ack_i = 1'b1;
    iwb_dat_i = 18'h12345;
    step();
    check("bb.c1.cyc", 32'(iwb_cyc_o), 32'h1);
    check("bb.c1.iack", 32'(inst_ack_o), 32'h0);
    step();
    check("bb.c2.iack", 32'(inst_ack_o), 32'h1);
    check("bb.c2.cyc", 32'(iwb_cyc_o), 32'h0);
    check("bb.c2.inst", 32'(inst_o), 32'h12345);
    step();
    iwb_dat_i = 18'h00007;
    check("bb.c3.iack", 32'(inst_ack_o), 32'h0);
    check("bb.c3.cyc", 32'(iwb_cyc_o), 32'h0);
    step();
    check("bb.c4.cyc", 32'(iwb_cyc_o), 32'h1);
    check("bb.c4.iack", 32'(inst_ack_o), 32'h0);
    request(1'b0, 12'h000);
    step();
    iwb_ack_i = 1'b0;
    check("bb.c5.iack", 32'(inst_ack_o), 32'h1);
    check("bb.c5.inst", 32'(inst_o), 32'h00007);
    check("bb.c5.func", 32'(func_o), 32'h7);
    step();
    check("bb.c6.iack", 32'(inst_ack_o), 32'h0);
    check("bb.c6.cyc", 32'(iwb_cyc_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
